// File: rtl/exe_muldiv.sv
// exe_muldiv: multi-cycle RV32M multiply/divide unit, one shift-add or restoring-subtract step per clock.
// Stalls the pipeline while busy and emits a single-cycle write-back pulse.
module exe_muldiv #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  logic [31:0]            inst_i,
    input  logic [DATA_WIDTH-1:0]  op1_i,
    input  logic [DATA_WIDTH-1:0]  op2_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   flush_i,
    output logic                   ready_o,
    output logic                   stall_o,
    output logic                   valid_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic [DATA_WIDTH-1:0]  reg_wdata_o
);
    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    state_e state_q, state_d;
    logic [W-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0] fn_q, fn_d;
    logic [RADDR_WIDTH-1:0] rd_q, rd_d;
    logic qneg_q, qneg_d, rneg_q, rneg_d;
    logic [2:0] f3;
    logic is_m, accept, sa, sb, na, nb, dz, special, unused_inst;
    logic [W-1:0] ma, mb, quo, rem, res;
    logic [W:0] sum, rsh, diff;
    logic [2*W-1:0] prod;
    assign f3          = inst_i[14:12];
    assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};
    assign is_m        = inst_i[6:0] == 7'b0110011 && inst_i[31:25] == 7'b0000001;
    assign ready_o     = state_q == IDLE;
    assign accept      = valid_i & ready_o & is_m & ~flush_i;
    assign stall_o     = (valid_i & is_m & ~ready_o) | (state_q == BUSY);
    assign sa          = f3 != 3'b011 && f3 != 3'b101 && f3 != 3'b111;
    assign sb          = sa && f3 != 3'b010;
    assign na          = sa & op1_i[W-1];
    assign nb          = sb & op2_i[W-1];
    assign ma          = na ? -op1_i : op1_i;
    assign mb          = nb ? -op2_i : op2_i;
    assign dz          = op2_i == '0;
    assign special     = f3[2] & (dz | (~f3[0] & op1_i == {1'b1, {(W-1){1'b0}}} & (&op2_i)));
    // Both algorithms share the {hi, lo} pair: lo holds multiplier or dividend/quotient, hi the partial product or remainder.
    assign sum         = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign rsh         = {hi_q, lo_q[W-1]};
    assign diff        = rsh - {1'b0, b_q};
    assign prod        = qneg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo         = qneg_q ? -lo_q : lo_q;
    assign rem         = rneg_q ? -hi_q : hi_q;
    assign res         = fn_q[2] ? (fn_q[1] ? rem : quo) : (fn_q[1:0] == 2'b00 ? prod[W-1:0] : prod[2*W-1:W]);
    assign valid_o     = state_q == DONE && !flush_i;
    assign reg_we_o    = valid_o;
    assign reg_waddr_o = valid_o ? rd_q : '0;
    assign reg_wdata_o = valid_o ? res : '0;
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        fn_d    = fn_q;
        rd_d    = rd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            IDLE: if (accept) begin
                fn_d    = f3;
                rd_d    = reg_waddr_i;
                cnt_d   = '0;
                b_d     = mb;
                hi_d    = special ? (dz ? op1_i : '0) : '0;
                lo_d    = special ? (dz ? '1 : op1_i) : ma;
                qneg_d  = ~special & (na ^ nb);
                rneg_d  = ~special & na;
                state_d = special ? DONE : BUSY;
            end
            BUSY: begin
                cnt_d   = cnt_q + 1'b1;
                hi_d    = fn_q[2] ? (diff[W] ? rsh[W-1:0] : diff[W-1:0]) : sum[W:1];
                lo_d    = fn_q[2] ? {lo_q[W-2:0], ~diff[W]} : {sum[0], lo_q[W-1:1]};
                state_d = flush_i ? IDLE : (cnt_q == LAST ? DONE : BUSY);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            fn_q    <= '0;
            rd_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            fn_q    <= fn_d;
            rd_q    <= rd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: directed vectors with hand-computed results for exe_muldiv at DATA_WIDTH=32.
module tb_exe_muldiv;
    localparam int W = 32;
    logic clk_i = 1'b0, rst_i = 1'b1, valid_i = 1'b0, flush_i = 1'b0;
    logic [31:0] inst_i = '0, op1_i = '0, op2_i = '0;
    logic [4:0] reg_waddr_i = '0;
    logic ready_o, stall_o, valid_o, reg_we_o;
    logic [4:0] reg_waddr_o;
    logic [31:0] reg_wdata_o;
    int nvec = 0, nfail = 0;
    exe_muldiv #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .CNT_WIDTH(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .inst_i(inst_i),
        .op1_i(op1_i), .op2_i(op2_i), .reg_waddr_i(reg_waddr_i), .flush_i(flush_i),
        .ready_o(ready_o), .stall_o(stall_o), .valid_o(valid_o), .reg_we_o(reg_we_o),
        .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
    );
    always #5 clk_i = ~clk_i;
    localparam logic [31:0] ADD = 32'h0000_0033;
    function automatic logic [31:0] mk(input logic [2:0] f3);
        return {7'b0000001, 10'd0, f3, 5'd0, 7'b0110011};
    endfunction
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic start(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        valid_i = 1'b1; inst_i = inst; op1_i = a; op2_i = b; reg_waddr_i = rd;
        @(posedge clk_i); #1;
        valid_i = 1'b0; op1_i = ~a; op2_i = ~b; reg_waddr_i = ~rd;
    endtask
    task automatic finish(input string tag, input logic [31:0] exp, input int exp_k, input logic [4:0] rd);
        int k, stalls;
        bit seen;
        k = 0; stalls = 0; seen = 1'b0;
        while (!seen && k <= W + 4) begin
            if (valid_o) seen = 1'b1;
            else begin
                stalls += int'(stall_o);
                @(posedge clk_i); #1;
                k++;
            end
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        chk({tag, "_lat"}, 64'(k), 64'(exp_k));
        chk({tag, "_stall"}, 64'(stalls), 64'(exp_k));
        chk({tag, "_data"}, 64'(reg_wdata_o), 64'(exp));
        chk({tag, "_we_rd"}, {58'd0, reg_we_o, reg_waddr_o}, {58'd0, 1'b1, rd});
        chk({tag, "_done_rdy"}, 64'(ready_o), 64'd0);
        @(posedge clk_i); #1;
        chk({tag, "_after"}, {61'd0, valid_o, reg_we_o, ready_o}, 64'b001);
    endtask
    task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int exp_k);
        start(mk(f3), a, b, rd);
        finish(tag, exp, exp_k, rd);
    endtask
    function automatic logic [63:0] outs();
        return {25'd0, ready_o, stall_o, valid_o, reg_we_o, reg_waddr_o, reg_wdata_o};
    endfunction
    localparam logic [63:0] RST_OUTS = {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
    initial begin
        int pulses;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_outs", outs(), RST_OUTS);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        run("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, W);
        run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, W);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF, W);
        run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, W);
        run("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, W);
        run("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, W);
        run("divu",   3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        W);
        run("remu",   3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         W);
        run("div0",   3'b100, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 0);
        run("rem0",   3'b110, 32'd5,         32'd0,         5'd14, 32'd5,         0);
        run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
        run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         0);
        start(mk(3'b101), 32'd100, 32'd7, 5'd17);
        pulses = 0;
        repeat (9) begin
            pulses += int'(valid_o);
            @(posedge clk_i); #1;
        end
        flush_i = 1'b1;
        pulses += int'(valid_o);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("flush_busy_pulses", 64'(pulses), 64'd0);
        chk("flush_busy_ready", {62'd0, ready_o, valid_o}, 64'b10);
        run("mul_after_flush", 3'b000, 32'd6, 32'd9, 5'd18, 32'd54, W);
        start(mk(3'b100), 32'd5, 32'd0, 5'd19);
        flush_i = 1'b1;
        #1;
        chk("flush_done_outs", {25'd0, valid_o, reg_we_o, reg_waddr_o, reg_wdata_o}, 64'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("flush_done_ready", {62'd0, ready_o, valid_o}, 64'b10);
        valid_i = 1'b1; inst_i = mk(3'b100); op1_i = 32'd5; op2_i = 32'd0; flush_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_idle_block", {62'd0, ready_o, valid_o}, 64'b10);
        start(mk(3'b000), 32'd3, 32'd4, 5'd20);
        repeat (5) @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        chk("rst_mid_busy", outs(), RST_OUTS);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        pulses = 0;
        repeat (W + 4) begin
            pulses += int'(valid_o);
            @(posedge clk_i); #1;
        end
        chk("rst_no_wb", 64'(pulses), 64'd0);
        start(mk(3'b000), 32'd11, 32'd13, 5'd21);
        valid_i = 1'b1; inst_i = ADD; op1_i = 32'd1; op2_i = 32'd2; reg_waddr_i = 5'd22;
        finish("mul_b2b", 32'd143, W, 5'd21);
        pulses = 0;
        repeat (4) begin
            pulses += int'(valid_o) + int'(!ready_o) + int'(stall_o);
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        chk("add_ignored", 64'(pulses), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
